// File: rtl/dac_filter_scheduler_if.sv
// Coefficient write port plus multiplier issue and write-back tags
// shared between the DAC filter sequencer and its host/datapath.
interface dac_filter_scheduler_if #(
  parameter int NUM_CH = 8
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic            coef_wr_en;
  logic [CH_W-1:0] coef_wr_ch;
  logic [15:0]     coef_wr_data;
  logic            issue_valid;
  logic [CH_W-1:0] issue_ch;
  logic [15:0]     issue_coef;
  logic            wb_valid;
  logic [CH_W-1:0] wb_ch;

  modport master (
    output coef_wr_en, coef_wr_ch, coef_wr_data,
    input  issue_valid, issue_ch, issue_coef,
    input  wb_valid, wb_ch
  );

  modport slave (
    input  coef_wr_en, coef_wr_ch, coef_wr_data,
    output issue_valid, issue_ch, issue_coef,
    output wb_valid, wb_ch
  );
endinterface

// File: rtl/dac_filter_scheduler.sv
// Frame sequencer sharing one filter multiplier across DAC channels,
// with a shadow/active coefficient bank swapped on frame acceptance.
module dac_filter_scheduler #(
  parameter int          NUM_CH       = 8,
  parameter int          MULT_LATENCY = 3,
  parameter logic [15:0] COEF_RESET   = 16'h0000
) (
  input  logic              dataclk,
  input  logic              reset_n,
  input  logic              frame_start,
  input  logic [NUM_CH-1:0] ch_enable,
  input  logic              coef_commit,
  input  logic              overrun_clr,
  output logic              busy,
  output logic              frame_done,
  output logic              commit_pending,
  output logic              overrun,
  dac_filter_scheduler_if.slave bus
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DC_W = $clog2(MULT_LATENCY + 1);
  localparam int L    = MULT_LATENCY;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic [DC_W-1:0]   dcnt_q, dcnt_d;
  logic [NUM_CH-1:0] en_q, en_d;

  logic [15:0]       shadow [NUM_CH];
  logic [15:0]       active [NUM_CH];

  logic              iv_q;
  logic [CH_W-1:0]   ich_q;
  logic [15:0]       icoef_q;
  logic [L-1:0]      tag_v;
  logic [CH_W-1:0]   tag_ch [L];
  logic              done_q, pend_q, ovr_q;

  logic              accept, commit_now;
  logic              last_slot, last_drain;
  logic [31:0]       wr_idx;
  logic              wr_ok;

  assign accept     = (state_q == IDLE) && frame_start;
  assign commit_now = accept && (pend_q || coef_commit);
  assign last_slot  = ptr_q == CH_W'(NUM_CH - 1);
  assign last_drain = dcnt_q == DC_W'(L - 1);
  assign wr_idx     = 32'(bus.coef_wr_ch);
  assign wr_ok      = wr_idx < 32'(NUM_CH);

  always_ff @(posedge dataclk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      dcnt_q  <= '0;
      en_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      dcnt_q  <= dcnt_d;
      en_q    <= en_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    dcnt_d  = dcnt_q;
    en_d    = en_q;
    unique case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d = ISSUE;
          ptr_d   = '0;
          en_d    = ch_enable;
        end
      end
      ISSUE: begin
        if (last_slot) begin
          state_d = DRAIN;
          dcnt_d  = '0;
        end else begin
          ptr_d = ptr_q + CH_W'(1);
        end
      end
      DRAIN: begin
        if (last_drain) state_d = IDLE;
        else dcnt_d = dcnt_q + DC_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Issue regs load from next-state so slot 0 lands right after acceptance
  always_ff @(posedge dataclk) begin
    if (!reset_n) begin
      iv_q    <= 1'b0;
      ich_q   <= '0;
      icoef_q <= '0;
      done_q  <= 1'b0;
      tag_v   <= '0;
      for (int i = 0; i < L; i++) tag_ch[i] <= '0;
    end else begin
      iv_q    <= (state_d == ISSUE) && en_d[ptr_d];
      ich_q   <= (state_d == ISSUE) ? ptr_d : '0;
      icoef_q <= (state_d != ISSUE) ? '0 :
                 commit_now ? shadow[ptr_d] : active[ptr_d];
      done_q  <= (state_q == DRAIN) && last_drain;
      tag_v[0]  <= iv_q;
      tag_ch[0] <= ich_q;
      for (int i = 1; i < L; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_ch[i] <= tag_ch[i-1];
      end
    end
  end

  always_ff @(posedge dataclk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow[i] <= COEF_RESET;
        active[i] <= COEF_RESET;
      end
    end else begin
      if (commit_now) begin
        for (int i = 0; i < NUM_CH; i++) active[i] <= shadow[i];
      end
      if (bus.coef_wr_en && wr_ok) begin
        shadow[bus.coef_wr_ch] <= bus.coef_wr_data;
      end
    end
  end

  always_ff @(posedge dataclk) begin
    if (!reset_n) begin
      pend_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      if (accept) pend_q <= 1'b0;
      else if (coef_commit) pend_q <= 1'b1;
      if (frame_start && state_q != IDLE) ovr_q <= 1'b1;
      else if (overrun_clr) ovr_q <= 1'b0;
    end
  end

  always_comb begin
    busy            = state_q != IDLE;
    frame_done      = done_q;
    commit_pending  = pend_q;
    overrun         = ovr_q;
    bus.issue_valid = iv_q;
    bus.issue_ch    = ich_q;
    bus.issue_coef  = icoef_q;
    bus.wb_valid    = tag_v[L-1];
    bus.wb_ch       = tag_ch[L-1];
  end
endmodule

// File: doc/dac_filter_scheduler.md
Name: dac_filter_scheduler

Overview:
- Time-multiplexes one shared 18x18 filter multiplier across NUM_CH DAC output channels.
- Replaces the per-DAC multiplier and state-update strobe with a single sequencer.
- Each sample frame it walks the channels in order, issues multiplier operations with each channel's filter coefficient, and tags the pipelined results for state write-back.
- Owns the per-channel coefficient bank (shadow plus active) so host writes take effect only on a frame boundary.

Parameters:
- NUM_CH, 8: number of DAC channels served; channel index width CH_W = $clog2(NUM_CH).
- MULT_LATENCY, 3: cycles from operand issue to valid multiplier product; must be 1 or greater.
- COEF_RESET, 16'h0000: reset value of every shadow and active coefficient.

Ports:
- dataclk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- frame_start  in  1  one-cycle pulse per sample frame, decoded from main_state.
- ch_enable  in  NUM_CH  per-channel filter enable; sampled at frame acceptance.
- coef_wr_en  in  1  write strobe into the shadow coefficient bank.
- coef_wr_ch  in  CH_W  shadow bank write index.
- coef_wr_data  in  16  shadow bank write data.
- coef_commit  in  1  pulse; request shadow-to-active copy at the next accepted frame.
- overrun_clr  in  1  clears the overrun flag.
- issue_valid  out  1  operand issue to the multiplier this cycle.
- issue_ch  out  CH_W  channel being issued.
- issue_coef  out  16  active coefficient of issue_ch.
- wb_valid  out  1  multiplier product valid; write back the filter state.
- wb_ch  out  CH_W  channel tag for wb_valid.
- busy  out  1  frame in progress (state is not IDLE).
- frame_done  out  1  one-cycle pulse on frame completion.
- commit_pending  out  1  a commit request is waiting for a frame.
- overrun  out  1  sticky; frame_start arrived while busy.

Behaviour:
- Reset (reset_n low at a clock edge): all outputs 0, state IDLE, ptr 0, tag pipeline cleared, all coefficients set to COEF_RESET.
- Reset mid-frame aborts the frame immediately. No wb_valid may emerge afterwards.
- State machine has three states: IDLE, ISSUE, DRAIN.
- IDLE:
  - On frame_start, the frame is accepted. Snapshot ch_enable into en_q, set ptr to 0, and go to ISSUE.
  - If commit_pending or coef_commit is set in the acceptance cycle, copy active from shadow and clear commit_pending.
  - The copy uses the shadow contents before that cycle's coef_wr_en write.
- ISSUE:
  - One cycle per channel, fixed timing regardless of enables.
  - issue_valid = en_q[ptr], issue_ch = ptr, issue_coef = active[ptr]. These outputs are registered and appear the cycle after ptr takes the value.
  - Disabled channels produce issue_valid=0 for that slot.
  - After slot NUM_CH-1, go to DRAIN.
- DRAIN: wait MULT_LATENCY cycles for the last tag to exit, then pulse frame_done for one cycle and return to IDLE.
- Timing: the first issue_valid appears 1 cycle after frame_start. Total busy time is NUM_CH + MULT_LATENCY cycles. frame_done is coincident with the first cycle busy=0.
- Tag pipeline: a shift register of {valid, ch} with depth MULT_LATENCY. wb_valid and wb_ch equal issue_valid and issue_ch delayed by exactly MULT_LATENCY cycles.
- Overrun:
  - frame_start while busy is ignored (no restart, no commit) and sets overrun.
  - frame_start in the frame_done cycle is accepted normally.
  - overrun_clr clears overrun. If clear and a new overrun occur in the same cycle, set wins.
- Shadow bank: writes are accepted in any state. The active bank never changes mid-frame.
- Commit requests while busy are held in commit_pending until the next accepted frame.
- Out-of-range coef_wr_ch (only possible when NUM_CH is not a power of 2) is ignored.

Test Plan:
- Reset, then frame_start with ch_enable=8'hFF → issue_valid high for 8 consecutive cycles with issue_ch 0..7; wb_valid is the same pattern 3 cycles later; frame_done 11 cycles after the first issue.
- Write coef ch3=16'h1234 with no commit, run a frame → issue_coef for ch3 is 16'h0000. Then coef_commit and the next frame → ch3 is 16'h1234 and commit_pending=0.
- ch_enable=8'b1010_0101 → issue_valid only in slots 0, 2, 5, 7; busy still lasts 11 cycles; wb_ch tags are 0, 2, 5, 7.
- frame_start 4 cycles into a frame → overrun=1 and the frame is unaffected. overrun_clr and a second mid-frame frame_start in the same cycle → overrun stays 1.
- reset_n low at issue slot 5 → all outputs 0 next cycle; no wb_valid for 5 cycles after release; the next frame is normal.
- frame_start in the frame_done cycle with coef_commit plus a shadow write to ch0 in that same cycle → new frame accepted; active ch0 holds the pre-write shadow value.
